palette_encoder: RTL

- Streaming inverse of the colour palette. Accepts 24-bit RGB pixels, for example from a sprite or asset loader, and maps each one to its 4-bit colour index.
- Packs the indices into words and writes them, with back-pressure, into sprite/background index RAM.
- Matching uses either the day table or the night table, selected per frame at start.

---
 rtl/palette_encoder_if.sv | 31 +++
 rtl/palette_encoder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/palette_encoder_if.sv
// Pixel-in / index-word-out bus of palette_encoder.
// slave is the encoder's view, master is the view of whoever drives pixels and owns the RAM.
interface palette_encoder_if #(
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 12
);
  logic                      start;
  logic                      isnight;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [7:0]                Red;
  logic [7:0]                Green;
  logic [7:0]                Blue;
  logic                      wr_en;
  logic                      wr_ready;
  logic [ADDR_W-1:0]         wr_addr;
  logic [4*PIX_PER_WORD-1:0] wr_data;
  logic                      done;
  logic [15:0]               miss_count;

  modport slave (
    input  start, isnight, in_valid, in_last, Red, Green, Blue, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, done, miss_count
  );

  modport master (
    output start, isnight, in_valid, in_last, Red, Green, Blue, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, done, miss_count
  );
endinterface

// File: rtl/palette_encoder.sv
// Maps 24-bit RGB pixels to 4-bit palette indices (day or night table) and packs them into RAM words.
// Define NEAREST_MATCH_EN to snap unmatched grey pixels to the closest grey table entry.
module palette_encoder #(
  parameter int PIX_PER_WORD = 4,
  parameter int ADDR_W       = 12
) (
  input logic              Clk,
  input logic              Reset_n,
  palette_encoder_if.slave io
);
  localparam int                FILL_W    = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int                WORD_W    = 4 * PIX_PER_WORD;
  localparam logic [FILL_W-1:0] LAST_SLOT = FILL_W'(PIX_PER_WORD - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Entry 10 first, entry 0 last.
  localparam logic [10:0][23:0] DAY_TBL = {
    24'hDADADA, 24'hB9B9B9, 24'h535353, 24'hFFFFFF, 24'hFEFEFE, 24'hF8F8F8,
    24'hA0A0A0, 24'hF6F6F6, 24'hF0F0F0, 24'hEFEFEF, 24'h800080
  };
  localparam logic [10:0][23:0] NIGHT_TBL = {
    24'hDADADA, 24'hB9B9B9, 24'hACACAC, 24'h000000, 24'h0E0E0E, 24'h080808,
    24'h202020, 24'h060606, 24'h000000, 24'h1F1F1F, 24'h800080
  };

  logic [1:0]        state;
  logic              night_q;
  logic [FILL_W-1:0] fill;
  logic [WORD_W-1:0] pack;
  logic [WORD_W-1:0] word;
  logic [10:0][23:0] tbl;
  logic [23:0]       pix;
  logic [3:0]        enc_idx;
  logic              enc_miss;
  logic              accept;
  logic              complete;
  logic              wr_fire;

`ifdef NEAREST_MATCH_EN
  logic [7:0] dist;
  logic [7:0] best_dist;
  logic [3:0] near_idx;
  logic       is_grey;
`endif

  assign pix         = {io.Red, io.Green, io.Blue};
  assign tbl         = night_q ? NIGHT_TBL : DAY_TBL;
  assign io.in_ready = (state == RUN) && (!io.wr_en || io.wr_ready);
  assign io.done     = (state == DONE);
  assign accept      = io.in_valid && io.in_ready;
  assign complete    = accept && ((fill == LAST_SLOT) || io.in_last);
  assign wr_fire     = io.wr_en && io.wr_ready;

  // Scanning from the top down lets the lowest matching index overwrite the others.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    enc_idx  = 4'hF;
    enc_miss = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      if (tbl[i] == pix) begin
        enc_idx  = 4'(i);
        enc_miss = 1'b0;
      end
    end
`ifdef NEAREST_MATCH_EN
    is_grey   = (io.Red == io.Green) && (io.Green == io.Blue);
    best_dist = 8'hFF;
    near_idx  = 4'hF;
    dist      = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if ((tbl[i][23:16] == tbl[i][15:8]) && (tbl[i][15:8] == tbl[i][7:0])) begin
        dist = (io.Red > tbl[i][7:0]) ? (io.Red - tbl[i][7:0]) : (tbl[i][7:0] - io.Red);
        if ((near_idx == 4'hF) || (dist < best_dist)) begin
          best_dist = dist;
          near_idx  = 4'(i);
        end
      end
    end
    if (enc_miss && is_grey && (near_idx != 4'hF)) begin
      enc_idx  = near_idx;
      enc_miss = 1'b0;
    end
`endif
  end

  // Pack register with the current pixel merged into its slot; upper slots stay 0.
  always_comb begin
    word                  = pack;
    word[{fill, 2'b00} +: 4] = enc_idx;
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      night_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          state   <= RUN;
          night_q <= io.isnight;
        end
        RUN:     if (accept && io.in_last) state <= DRAIN;
        DRAIN:   if (wr_fire) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fill <= '0;
      pack <= '0;
    end else if ((state == IDLE) && io.start) begin
      fill <= '0;
      pack <= '0;
    end else if (complete) begin
      fill <= '0;
      pack <= '0;
    end else if (accept) begin
      fill <= fill + 1'b1;
      pack <= word;
    end
  end

  // A completing pixel can only be accepted when the output is free or handshaking,
  // so loading a new word always wins over clearing wr_en.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io.wr_en   <= 1'b0;
      io.wr_data <= '0;
    end else if (complete) begin
      io.wr_en   <= 1'b1;
      io.wr_data <= word;
    end else if (wr_fire) begin
      io.wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io.wr_addr <= '0;
    end else if ((state == IDLE) && io.start) begin
      io.wr_addr <= '0;
    end else if (wr_fire) begin
      io.wr_addr <= io.wr_addr + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      io.miss_count <= '0;
    end else if ((state == IDLE) && io.start) begin
      io.miss_count <= '0;
    end else if (accept && enc_miss && (io.miss_count != 16'hFFFF)) begin
      io.miss_count <= io.miss_count + 16'd1;
    end
  end
endmodule
